// File: rtl/tiempo_muerto_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tiempo_muerto_pwm
//  Description : Dead-time stage placed after the PWM comparator. It turns
//                the single PWM bit into complementary high-side and low-side
//                gate commands. Every commutation gets a programmable interval
//                in which both gates are off. Both gates are forced off when
//                the stage is disabled or a fault is present. A fault stays
//                latched until it is explicitly cleared.
//
//  Ports       : clk           - system clock, rising edge
//                reset         - synchronous, active-high reset
//                PWM_In        - PWM bit from the comparator (same domain)
//                Enable        - 1 = drive gates, 0 = both gates off
//                Dead_Time     - dead-time length in clk cycles (0 acts as 1)
//                Fault         - external fault level, active-high
//                Fault_Clr     - one-cycle pulse that clears a latched fault
//                Gate_H        - high-side switch command
//                Gate_L        - low-side switch command
//                Fault_Latched - 1 while the fault is latched
//                DT_Active     - 1 while a dead-time interval is running
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tiempo_muerto_pwm #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PWM_In,
    input  logic            Enable,
    input  logic [DT_W-1:0] Dead_Time,
    input  logic            Fault,
    input  logic            Fault_Clr,
    output logic            Gate_H,
    output logic            Gate_L,
    output logic            Fault_Latched,
    output logic            DT_Active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DT_TO_H = 3'd1,
        S_ON_H    = 3'd2,
        S_DT_TO_L = 3'd3,
        S_ON_L    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [DT_W-1:0] c_one = DT_W'(1);

    state_t          r_state;
    logic [DT_W-1:0] r_count;
    logic            r_pwm_q;
    // Set when the running dead-time was entered from IDLE, i.e. there is no
    // previously conducting gate to fall back to on an abort.
    logic            r_from_idle;
    logic            r_gate_h;
    logic            r_gate_l;
    logic            r_fault_latched;
    logic            r_dt_active;

    state_t          w_state_nxt;
    logic [DT_W-1:0] w_count_nxt;
    logic            w_from_idle_nxt;
    logic [DT_W-1:0] w_dt_load;

    // A zero dead time would make the counter start at its exit value minus
    // one and wrap; clamp it so the counter is never loaded with 0.
    assign w_dt_load = (Dead_Time == '0) ? c_one : Dead_Time;

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: Fault > !Enable > normal transitions.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_from_idle_nxt = r_from_idle;

        if (r_state == S_FAULT) begin
            // Clearing is only honoured once the external fault has gone away.
            if (Fault_Clr && !Fault) begin
                w_state_nxt = S_IDLE;
            end
        end else if (Fault) begin
            w_state_nxt = S_FAULT;
        end else if (!Enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt     = r_pwm_q ? S_DT_TO_H : S_DT_TO_L;
                    w_count_nxt     = w_dt_load;
                    w_from_idle_nxt = 1'b1;
                end
                S_ON_H: begin
                    if (!r_pwm_q) begin
                        w_state_nxt     = S_DT_TO_L;
                        w_count_nxt     = w_dt_load;
                        w_from_idle_nxt = 1'b0;
                    end
                end
                S_ON_L: begin
                    if (r_pwm_q) begin
                        w_state_nxt     = S_DT_TO_H;
                        w_count_nxt     = w_dt_load;
                        w_from_idle_nxt = 1'b0;
                    end
                end
                S_DT_TO_H: begin
                    if (!r_pwm_q) begin
                        // PWM went back low before the interval finished.
                        if (r_from_idle) begin
                            w_state_nxt = S_DT_TO_L;
                            w_count_nxt = w_dt_load;
                        end else begin
                            // Low side was on before; it is safe to resume it
                            // because the high side never turned on.
                            w_state_nxt = S_ON_L;
                        end
                    end else if (r_count == c_one) begin
                        w_state_nxt = S_ON_H;
                    end else begin
                        w_count_nxt = r_count - c_one;
                    end
                end
                S_DT_TO_L: begin
                    if (r_pwm_q) begin
                        if (r_from_idle) begin
                            w_state_nxt = S_DT_TO_H;
                            w_count_nxt = w_dt_load;
                        end else begin
                            w_state_nxt = S_ON_H;
                        end
                    end else if (r_count == c_one) begin
                        w_state_nxt = S_ON_L;
                    end else begin
                        w_count_nxt = r_count - c_one;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, input register and outputs. The outputs are registered and are
    // decoded from the next state, so they always agree with r_state and have
    // no combinational path from any input.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_pwm_q         <= 1'b0;
            r_from_idle     <= 1'b0;
            r_gate_h        <= 1'b0;
            r_gate_l        <= 1'b0;
            r_fault_latched <= 1'b0;
            r_dt_active     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_pwm_q         <= PWM_In;
            r_from_idle     <= w_from_idle_nxt;
            r_gate_h        <= (w_state_nxt == S_ON_H);
            r_gate_l        <= (w_state_nxt == S_ON_L);
            r_fault_latched <= (w_state_nxt == S_FAULT);
            r_dt_active     <= (w_state_nxt == S_DT_TO_H) ||
                               (w_state_nxt == S_DT_TO_L);
        end
    end

    assign Gate_H        = r_gate_h;
    assign Gate_L        = r_gate_l;
    assign Fault_Latched = r_fault_latched;
    assign DT_Active     = r_dt_active;

endmodule
`default_nettype wire
